pcs_sync_supervisor: RTL

PCS_SYNC_SUPERVISOR -- requirements
Module: pcs_sync_supervisor

---
 rtl/pcs_sync_supervisor.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pcs_sync_supervisor.sv
// pcs_sync_supervisor: receive code-group alignment and sync-state supervisor.
// Define ERR_COUNTER_EN to add the saturating code_err_count output.
module pcs_sync_supervisor #(
  parameter int unsigned ACQ_COMMAS = 3,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned GOOD_CGS   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        signal_detect,
  input  logic        code_valid,
  input  logic [9:0]  rx_code_group_in,
  output logic [9:0]  rx_code_group_out,
  output logic        code_out_valid,
  output logic        rx_even,
  output logic        sync_status
`ifdef ERR_COUNTER_EN
  ,
  output logic [15:0] code_err_count
`endif
);

  typedef enum logic [2:0] {
    ST_LOSS = 3'd0,
    ST_CDET = 3'd1,
    ST_ACQ  = 3'd2,
    ST_SACQ = 3'd3,
    ST_SERR = 3'd4
  } state_t;

  localparam logic [2:0] ACQ_N  = 3'(ACQ_COMMAS);
  localparam logic [2:0] ERR_N  = 3'(ERR_LIMIT);
  localparam logic [3:0] GOOD_N = 4'(GOOD_CGS);

  localparam logic [9:0] K28_5_P = 10'b1100000101;
  localparam logic [9:0] K28_5_M = 10'b0011111010;

  state_t     state_q, state_d;
  logic [2:0] comma_cnt_q, comma_cnt_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [9:0] rx_cg_q, rx_cg_d;
  logic       out_vld_q, out_vld_d;
  logic       rx_even_q, rx_even_d;
  logic       sync_q, sync_d;

  logic [5:0] cg6;
  logic [3:0] cg4;
  logic       d6_ok, d4_ok;
  logic       is_comma, is_data, is_ctrl, is_inv;
  logic       odd_comma, bad_cg;
  logic [2:0] comma_inc, err_inc, err_dec;
  logic [3:0] good_inc;

  assign cg6 = rx_code_group_in[9:4];
  assign cg4 = rx_code_group_in[3:0];

  // 6b sub-block of D0..D9, either running disparity
  always_comb begin
    d6_ok = 1'b0;
    case (cg6)
      6'b100111, 6'b011000,
      6'b011101, 6'b100010,
      6'b101101, 6'b010010,
      6'b110001,
      6'b110101, 6'b001010,
      6'b101001,
      6'b011001,
      6'b111000, 6'b000111,
      6'b111001, 6'b000110,
      6'b100101: d6_ok = 1'b1;
      default:   d6_ok = 1'b0;
    endcase
  end

  // 4b sub-block of Dx.0..Dx.7 including the alternate x.7 encoding
  always_comb begin
    d4_ok = 1'b0;
    case (cg4)
      4'b1011, 4'b0100,
      4'b1001,
      4'b0101,
      4'b1100, 4'b0011,
      4'b1101, 4'b0010,
      4'b1010,
      4'b0110,
      4'b1110, 4'b0001,
      4'b0111, 4'b1000: d4_ok = 1'b1;
      default:          d4_ok = 1'b0;
    endcase
  end

  // code-group class: comma wins, then data, then K23.7/K27.7/K29.7
  always_comb begin
    is_comma = (rx_code_group_in == K28_5_P) ||
               (rx_code_group_in == K28_5_M);
    is_data  = ~is_comma &&
               ((rx_code_group_in == 10'b1010010110) ||
                (d6_ok && d4_ok));
    is_ctrl  = 1'b0;
    case (rx_code_group_in)
      10'b1110101000, 10'b0001010111,
      10'b1101101000, 10'b0010010111,
      10'b1011101000, 10'b0100010111: is_ctrl = 1'b1;
      default:                        is_ctrl = 1'b0;
    endcase
    is_inv    = ~(is_comma | is_data | is_ctrl);
    odd_comma = is_comma & rx_even_q;
    bad_cg    = is_inv | odd_comma;
  end

  // saturating counter arithmetic so no counter can wrap
  always_comb begin
    comma_inc = (comma_cnt_q == 3'd7) ? 3'd7 : comma_cnt_q + 3'd1;
    err_inc   = (err_cnt_q == 3'd7) ? 3'd7 : err_cnt_q + 3'd1;
    err_dec   = (err_cnt_q == 3'd0) ? 3'd0 : err_cnt_q - 3'd1;
    good_inc  = (good_cnt_q == 4'd15) ? 4'd15 : good_cnt_q + 4'd1;
  end

  // next-state, counters and registered datapath outputs
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    rx_cg_d     = rx_cg_q;
    rx_even_d   = rx_even_q;
    out_vld_d   = 1'b0;
    if (!signal_detect) begin
      state_d     = ST_LOSS;
      comma_cnt_d = 3'd0;
      err_cnt_d   = 3'd0;
      good_cnt_d  = 4'd0;
      rx_even_d   = 1'b0;
    end else if (code_valid) begin
      rx_cg_d   = rx_code_group_in;
      out_vld_d = 1'b1;
      rx_even_d = is_comma ? 1'b1 : ~rx_even_q;
      unique case (state_q)
        ST_LOSS: begin
          if (is_comma) begin
            state_d     = ST_CDET;
            comma_cnt_d = 3'd1;
          end
        end
        ST_CDET: begin
          if (is_data) begin
            state_d = ST_ACQ;
          end else begin
            state_d     = ST_LOSS;
            comma_cnt_d = 3'd0;
          end
        end
        ST_ACQ: begin
          if (bad_cg) begin
            state_d     = ST_LOSS;
            comma_cnt_d = 3'd0;
          end else if (is_comma) begin
            comma_cnt_d = comma_inc;
            state_d = (comma_inc >= ACQ_N) ? ST_SACQ : ST_CDET;
          end
        end
        ST_SACQ: begin
          if (bad_cg) begin
            state_d    = ST_SERR;
            err_cnt_d  = 3'd1;
            good_cnt_d = 4'd0;
          end
        end
        ST_SERR: begin
          if (bad_cg) begin
            good_cnt_d = 4'd0;
            if (err_inc >= ERR_N) begin
              state_d     = ST_LOSS;
              comma_cnt_d = 3'd0;
              err_cnt_d   = 3'd0;
            end else begin
              err_cnt_d = err_inc;
            end
          end else if (good_inc >= GOOD_N) begin
            good_cnt_d = 4'd0;
            err_cnt_d  = err_dec;
            if (err_dec == 3'd0) begin
              state_d = ST_SACQ;
            end
          end else begin
            good_cnt_d = good_inc;
          end
        end
        default: begin
          state_d     = ST_LOSS;
          comma_cnt_d = 3'd0;
          err_cnt_d   = 3'd0;
          good_cnt_d  = 4'd0;
        end
      endcase
    end
    sync_d = (state_d == ST_SACQ) || (state_d == ST_SERR);
  end

  // all supervisor state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_LOSS;
      comma_cnt_q <= 3'd0;
      err_cnt_q   <= 3'd0;
      good_cnt_q  <= 4'd0;
      rx_cg_q     <= 10'd0;
      out_vld_q   <= 1'b0;
      rx_even_q   <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      rx_cg_q     <= rx_cg_d;
      out_vld_q   <= out_vld_d;
      rx_even_q   <= rx_even_d;
      sync_q      <= sync_d;
    end
  end

  assign rx_code_group_out = rx_cg_q;
  assign code_out_valid    = out_vld_q;
  assign rx_even           = rx_even_q;
  assign sync_status       = sync_q;

`ifdef ERR_COUNTER_EN
  logic [15:0] cg_err_q, cg_err_d;

  // count bad groups seen while synchronised, saturating
  always_comb begin
    cg_err_d = cg_err_q;
    if (signal_detect && code_valid && sync_q && bad_cg &&
        (cg_err_q != 16'hFFFF)) begin
      cg_err_d = cg_err_q + 16'd1;
    end
  end

  // error counter storage, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cg_err_q <= 16'd0;
    end else begin
      cg_err_q <= cg_err_d;
    end
  end

  assign code_err_count = cg_err_q;
`endif

endmodule
